// File: rtl/user_gpio_irq_pkg.sv
// Shared definitions for the user GPIO interrupt controller: register map,
// bus state encoding and the byte-enable expansion helper.
package user_gpio_irq_pkg;

  localparam logic [7:0] OFF_OUT       = 8'h00;
  localparam logic [7:0] OFF_OEB       = 8'h04;
  localparam logic [7:0] OFF_IN        = 8'h08;
  localparam logic [7:0] OFF_RISE_EN   = 8'h0C;
  localparam logic [7:0] OFF_FALL_EN   = 8'h10;
  localparam logic [7:0] OFF_RISE_STAT = 8'h14;
  localparam logic [7:0] OFF_FALL_STAT = 8'h18;
  localparam logic [7:0] OFF_ID        = 8'h1C;

  localparam logic [31:0] ID_DEFAULT = 32'h4750_4931;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_e;

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/gpio_edge_sync.sv
// Two-flop synchroniser plus history flop for a W-bit pad vector, producing
// the synchronised value and single-cycle rise/fall pulses.
module gpio_edge_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] async_in,
  output logic [W-1:0] sync_out,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;
  logic [W-1:0] prev_r;

  // synchroniser chain and previous-value history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= '0;
      sync_r <= '0;
      prev_r <= '0;
    end else begin
      meta_r <= async_in;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign sync_out = sync_r;
  assign rise     = sync_r & ~prev_r;
  assign fall     = ~sync_r & prev_r;

endmodule

// File: rtl/user_gpio_irq_ctrl.sv
// Wishbone-slave GPIO block: output/enable registers, synchronised inputs and
// W1C edge-status registers feeding three registered interrupt lines.
module user_gpio_irq_ctrl
  import user_gpio_irq_pkg::*;
#(
  parameter int unsigned NUM_IO    = 27,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ID_VALUE  = ID_DEFAULT
) (
  input  logic              wb_clk_i,
  input  logic              wb_rstn_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic [2:0]        user_irq
);

  bus_state_e        state_r;
  bus_state_e        state_nxt_s;
  logic              addr_hit_s;
  logic              access_s;
  logic              ack_s;
  logic              wr_s;
  logic              rd_s;
  logic [7:0]        off_s;
  logic [31:0]       be_full_s;
  logic [NUM_IO-1:0] be_s;
  logic [NUM_IO-1:0] wdat_s;
  logic              unused_s;
  logic [31:0]       rdata_s;

  logic [NUM_IO-1:0] sync_s;
  logic [NUM_IO-1:0] rise_s;
  logic [NUM_IO-1:0] fall_s;
  logic [NUM_IO-1:0] rclr_s;
  logic [NUM_IO-1:0] fclr_s;

  logic [NUM_IO-1:0] out_r;
  logic [NUM_IO-1:0] oeb_r;
  logic [NUM_IO-1:0] ren_r;
  logic [NUM_IO-1:0] fen_r;
  logic [NUM_IO-1:0] rstat_r;
  logic [NUM_IO-1:0] fstat_r;
  logic [31:0]       dat_r;
  logic [2:0]        irq_r;

  assign off_s      = wbs_adr_i[7:0];
  assign addr_hit_s = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign be_full_s  = byte_mask(wbs_sel_i);
  assign be_s       = be_full_s[NUM_IO-1:0];
  assign wdat_s     = wbs_dat_i[NUM_IO-1:0];
  // bits above NUM_IO are architecturally ignored on writes
  assign unused_s   = ^{be_full_s, wbs_dat_i};
  assign wr_s       = access_s & wbs_we_i;
  assign rd_s       = access_s & ~wbs_we_i;

  gpio_edge_sync #(.W(NUM_IO)) u_edge_sync (
    .clk      (wb_clk_i),
    .rst_n    (wb_rstn_i),
    .async_in (io_in),
    .sync_out (sync_s),
    .rise     (rise_s),
    .fall     (fall_s)
  );

  // bus FSM state register
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // bus FSM next-state logic
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (access_s) state_nxt_s = ST_ACK;
        else          state_nxt_s = ST_IDLE;
      end
      ST_ACK:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // bus FSM outputs; the ACK state itself blocks a second access
  always_comb begin
    ack_s    = 1'b0;
    access_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ack_s    = 1'b0;
        access_s = wbs_stb_i & wbs_cyc_i & addr_hit_s;
      end
      ST_ACK: begin
        ack_s    = 1'b1;
        access_s = 1'b0;
      end
      default: begin
        ack_s    = 1'b0;
        access_s = 1'b0;
      end
    endcase
  end

  assign wbs_ack_o = ack_s;

  // read-data mux, zero-extended to the bus width
  always_comb begin
    rdata_s = '0;
    case (off_s)
      OFF_OUT:       rdata_s[NUM_IO-1:0] = out_r;
      OFF_OEB:       rdata_s[NUM_IO-1:0] = oeb_r;
      OFF_IN:        rdata_s[NUM_IO-1:0] = sync_s;
      OFF_RISE_EN:   rdata_s[NUM_IO-1:0] = ren_r;
      OFF_FALL_EN:   rdata_s[NUM_IO-1:0] = fen_r;
      OFF_RISE_STAT: rdata_s[NUM_IO-1:0] = rstat_r;
      OFF_FALL_STAT: rdata_s[NUM_IO-1:0] = fstat_r;
      OFF_ID:        rdata_s = ID_VALUE;
      default:       rdata_s = 32'h0000_0000;
    endcase
  end

  // read data capture, held until the next read
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      dat_r <= 32'h0000_0000;
    end else if (rd_s) begin
      dat_r <= rdata_s;
    end else begin
      dat_r <= dat_r;
    end
  end

  assign wbs_dat_o = dat_r;

  // read/write control registers with per-byte enables
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      out_r <= '0;
      oeb_r <= '1;
      ren_r <= '0;
      fen_r <= '0;
    end else if (wr_s) begin
      case (off_s)
        OFF_OUT:     out_r <= (out_r & ~be_s) | (wdat_s & be_s);
        OFF_OEB:     oeb_r <= (oeb_r & ~be_s) | (wdat_s & be_s);
        OFF_RISE_EN: ren_r <= (ren_r & ~be_s) | (wdat_s & be_s);
        OFF_FALL_EN: fen_r <= (fen_r & ~be_s) | (wdat_s & be_s);
        default: begin
          out_r <= out_r;
          oeb_r <= oeb_r;
          ren_r <= ren_r;
          fen_r <= fen_r;
        end
      endcase
    end else begin
      out_r <= out_r;
      oeb_r <= oeb_r;
      ren_r <= ren_r;
      fen_r <= fen_r;
    end
  end

  assign io_out = out_r;
  assign io_oeb = oeb_r;

  // write-one-to-clear masks for the status registers
  always_comb begin
    rclr_s = '0;
    fclr_s = '0;
    if (wr_s && (off_s == OFF_RISE_STAT)) begin
      rclr_s = wdat_s & be_s;
    end else if (wr_s && (off_s == OFF_FALL_STAT)) begin
      fclr_s = wdat_s & be_s;
    end else begin
      rclr_s = '0;
      fclr_s = '0;
    end
  end

  // edge status: the hardware set is OR-ed in after the clear so it wins
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      rstat_r <= '0;
      fstat_r <= '0;
    end else begin
      rstat_r <= (rstat_r & ~rclr_s) | (rise_s & ren_r);
      fstat_r <= (fstat_r & ~fclr_s) | (fall_s & fen_r);
    end
  end

  // registered interrupt lines
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      irq_r <= 3'b000;
    end else begin
      irq_r <= {|(rstat_r | fstat_r), |fstat_r, |rstat_r};
    end
  end

  assign user_irq = irq_r;

endmodule

// File: tb/tb_user_gpio_irq_ctrl.sv
// Self-checking bench for user_gpio_irq_ctrl: register vector table, timed
// interrupt corner cases and a randomized run against an event-level model.
module tb_user_gpio_irq_ctrl;

  localparam int          NIO  = 27;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] MASK = 32'h07FF_FFFF;
  localparam logic [31:0] A_OUT = 32'h00, A_OEB = 32'h04, A_IN = 32'h08, A_REN = 32'h0C;
  localparam logic [31:0] A_FEN = 32'h10, A_RST = 32'h14, A_FST = 32'h18, A_ID = 32'h1C;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           stb, cyc, we;
  logic [3:0]     sel;
  logic [31:0]    adr, wdat;
  logic           ack;
  logic [31:0]    rdat;
  logic [NIO-1:0] io_in, io_out, io_oeb;
  logic [2:0]     irq;

  int errors = 0;
  int checks = 0;

  user_gpio_irq_ctrl dut (
    .wb_clk_i (clk),
    .wb_rstn_i(rst_n),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .user_irq (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] off;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus access; returns #1 after the edge on which ack is seen.
  task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, input int budget,
                          output logic [31:0] rd, output logic acked);
    adr = a; wdat = d; sel = s; we = w; stb = 1'b1; cyc = 1'b1;
    acked = 1'b0; rd = 32'h0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        acked = 1'b1;
        rd = rdat;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    logic a;
    wb_cycle(BASE + off, 1'b1, d, s, 16, r, a);
    check($sformatf("wr_ack@%h", off), {31'd0, a}, 32'd1);
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] d);
    logic a;
    wb_cycle(BASE + off, 1'b0, 32'h0, 4'hF, 16, d, a);
    check($sformatf("rd_ack@%h", off), {31'd0, a}, 32'd1);
  endtask

  task automatic rd_check(input string name, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] d;
    rd(off, d);
    check(name, d, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
    sel = 4'h0; adr = 32'h0; wdat = 32'h0; io_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r & MASK;
  endfunction

  function automatic logic [31:0] clr_mask(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r & MASK;
  endfunction

  function automatic logic [31:0] irq_of(input logic [31:0] rs, input logic [31:0] fs);
    return {29'd0, (rs | fs) != 32'h0, fs != 32'h0, rs != 32'h0};
  endfunction

  initial begin
    logic [31:0] d;
    logic        a;
    logic [31:0] m_reg[4];
    logic [31:0] m_rs, m_fs, m_in, new_in, rise, fall, dv;
    logic [3:0]  sv;
    int          idx;
    logic [31:0] raddr[4];

    raddr[0] = A_OUT; raddr[1] = A_OEB; raddr[2] = A_REN; raddr[3] = A_FEN;

    tbl[0]  = '{A_OUT, 32'hFFFF_FFFF, 4'b0010, 32'h0000_FF00};
    tbl[1]  = '{A_OUT, 32'hFFFF_FFFF, 4'b1111, 32'h07FF_FFFF};
    tbl[2]  = '{A_OUT, 32'h0000_0000, 4'b0001, 32'h07FF_FF00};
    tbl[3]  = '{A_OEB, 32'h1234_5678, 4'b1111, 32'h0234_5678};
    tbl[4]  = '{A_OEB, 32'hFFFF_FFFF, 4'b1000, 32'h0734_5678};
    tbl[5]  = '{A_REN, 32'hA5A5_A5A5, 4'b0101, 32'h00A5_00A5};
    tbl[6]  = '{A_FEN, 32'h5A5A_5A5A, 4'b1010, 32'h0200_5A00};
    tbl[7]  = '{A_ID,  32'h0000_0000, 4'b1111, 32'h4750_4931};
    tbl[8]  = '{A_IN,  32'hFFFF_FFFF, 4'b1111, 32'h0000_1234};
    tbl[9]  = '{32'h20, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
    tbl[10] = '{32'h40, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
    tbl[11] = '{32'hFC, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};

    // reset state
    do_reset();
    check("rst_oeb", {5'd0, io_oeb}, 32'h07FF_FFFF);
    check("rst_out", {5'd0, io_out}, 32'h0);
    check("rst_irq", {29'd0, irq}, 32'h0);
    check("rst_ack", {31'd0, ack}, 32'h0);
    check("rst_dat", rdat, 32'h0);
    rd_check("rst_id", A_ID, 32'h4750_4931);

    // register vector table
    io_in = 27'h000_1234;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      wr(tbl[i].off, tbl[i].wd, tbl[i].be);
      rd_check($sformatf("tbl[%0d]", i), tbl[i].off, tbl[i].exp);
    end
    check("tbl_io_out", {5'd0, io_out}, 32'h07FF_FF00);
    check("tbl_io_oeb", {5'd0, io_oeb}, 32'h0734_5678);
    rd_check("tbl_no_stat", A_RST, 32'h0);

    // rising edge latency and W1C release
    do_reset();
    wr(A_REN, 32'h1, 4'hF);
    io_in = 27'h1;
    repeat (3) @(posedge clk);
    #1 check("rise_irq_n2", {29'd0, irq}, 32'h0);
    @(posedge clk);
    #1 check("rise_irq_n3", {29'd0, irq}, 32'h5);
    rd_check("rise_stat", A_RST, 32'h1);
    rd_check("rise_fstat", A_FST, 32'h0);
    rd_check("rise_in", A_IN, 32'h1);
    wr(A_RST, 32'h1, 4'hF);
    check("w1c_irq_ackedge", {29'd0, irq}, 32'h5);
    @(posedge clk);
    #1 check("w1c_irq_after", {29'd0, irq}, 32'h0);
    rd_check("w1c_stat", A_RST, 32'h0);

    // falling-edge status, enable removal, set/clear collision
    do_reset();
    wr(A_FEN, 32'h8, 4'hF);
    io_in = 27'h8;
    repeat (5) @(posedge clk);
    #1;
    rd_check("fall_none_on_rise", A_FST, 32'h0);
    io_in = 27'h0;
    repeat (5) @(posedge clk);
    #1;
    rd_check("fall_stat", A_FST, 32'h8);
    check("fall_irq", {29'd0, irq}, 32'h6);
    wr(A_FEN, 32'h0, 4'hF);
    rd_check("fall_keep_on_disable", A_FST, 32'h8);
    wr(A_FEN, 32'h8, 4'hF);
    io_in = 27'h8;
    repeat (5) @(posedge clk);
    #1;
    io_in = 27'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr(A_FST, 32'h8, 4'hF);
    @(posedge clk); #1;
    rd_check("collide_stat", A_FST, 32'h8);
    check("collide_irq", {29'd0, irq}, 32'h6);
    wr(A_FST, 32'h8, 4'hF);
    @(posedge clk); #1;
    check("clear_irq", {29'd0, irq}, 32'h0);
    rd_check("clear_stat", A_FST, 32'h0);

    // address decode outside the page
    wb_cycle(BASE + 32'h100, 1'b0, 32'h0, 4'hF, 16, d, a);
    check("no_ack_page1", {31'd0, a}, 32'h0);
    wb_cycle(32'h3100_0000, 1'b1, 32'hFFFF_FFFF, 4'hF, 16, d, a);
    check("no_ack_other", {31'd0, a}, 32'h0);
    rd_check("no_write_other", A_OUT, 32'h0);

    // reset while in the ACK state
    wr(A_REN, 32'h1, 4'hF);
    io_in = 27'h1;
    repeat (5) @(posedge clk);
    #1 check("pre_rst_irq", {29'd0, irq}, 32'h5);
    adr = BASE + A_OUT; wdat = 32'hFFFF_FFFF; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    @(posedge clk);
    #1 check("mid_ack_high", {31'd0, ack}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_ack_low", {31'd0, ack}, 32'h0);
    check("mid_out", {5'd0, io_out}, 32'h0);
    check("mid_oeb", {5'd0, io_oeb}, 32'h07FF_FFFF);
    check("mid_irq", {29'd0, irq}, 32'h0);
    check("mid_dat", rdat, 32'h0);
    stb = 1'b0; cyc = 1'b0; we = 1'b0; io_in = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    rd_check("mid_out_reg", A_OUT, 32'h0);
    rd_check("mid_ren_reg", A_REN, 32'h0);
    rd_check("mid_rstat_reg", A_RST, 32'h0);

    // randomized run against the event-level model
    do_reset();
    m_reg[0] = 32'h0; m_reg[1] = MASK; m_reg[2] = 32'h0; m_reg[3] = 32'h0;
    m_rs = 32'h0; m_fs = 32'h0; m_in = 32'h0;
    for (int it = 0; it < 30; it++) begin
      idx = $urandom_range(0, 3);
      dv = $urandom;
      sv = 4'($urandom_range(0, 15));
      wr(raddr[idx], dv, sv);
      m_reg[idx] = merge(m_reg[idx], dv, sv);
      rd_check($sformatf("rnd%0d_reg", it), raddr[idx], m_reg[idx]);
      check($sformatf("rnd%0d_io_out", it), {5'd0, io_out}, m_reg[0]);
      check($sformatf("rnd%0d_io_oeb", it), {5'd0, io_oeb}, m_reg[1]);

      new_in = $urandom & MASK;
      io_in = new_in[NIO-1:0];
      repeat (4) @(posedge clk);
      #1;
      rise = new_in & ~m_in;
      fall = ~new_in & m_in & MASK;
      m_rs = m_rs | (rise & m_reg[2]);
      m_fs = m_fs | (fall & m_reg[3]);
      m_in = new_in;
      rd_check($sformatf("rnd%0d_in", it), A_IN, m_in);
      rd_check($sformatf("rnd%0d_rstat", it), A_RST, m_rs);
      rd_check($sformatf("rnd%0d_fstat", it), A_FST, m_fs);
      check($sformatf("rnd%0d_irq", it), {29'd0, irq}, irq_of(m_rs, m_fs));

      dv = $urandom;
      sv = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        wr(A_RST, dv, sv);
        m_rs = m_rs & ~clr_mask(dv, sv);
      end else begin
        wr(A_FST, dv, sv);
        m_fs = m_fs & ~clr_mask(dv, sv);
      end
      @(posedge clk); #1;
      check($sformatf("rnd%0d_irq_clr", it), {29'd0, irq}, irq_of(m_rs, m_fs));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
